// File: rtl/cam_update_all_loader.sv
// UPDATE_ALL loader: takes packed entry beats after the command word, unpacks
// them and writes one CAM entry per cycle from address 0 upward, then signals completion.
module cam_update_all_loader #(
    parameter int C_DATA_WIDTH  = 512,
    parameter int OP_CODE_WIDTH = 3,
    parameter int ENTRY_WIDTH   = 64,
    parameter int CAM_DEPTH     = 1024,
    parameter int ADDR_WIDTH    = $clog2(CAM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_CODE_WIDTH-1:0] state,
    input  logic [31:0]              update_num,
    input  logic [C_DATA_WIDTH-1:0]  s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [ENTRY_WIDTH-1:0]   wr_data,
    output logic                     update_all_end,
    output logic                     overflow,
    output logic [31:0]              entries_written
);
    localparam int EPB    = C_DATA_WIDTH / ENTRY_WIDTH;
    localparam int SLOT_W = $clog2(EPB + 1);

    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_WRITE, L_DONE} lstate_e;

    lstate_e                 lstate_q, lstate_d;
    logic                    state1_prev_q;
    logic                    in_upd, trigger;
    logic [31:0]             remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [SLOT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [C_DATA_WIDTH-1:0] buf_q, buf_d;
    logic [31:0]             entries_written_q, entries_written_d;
    logic                    overflow_q, overflow_d;
    logic                    s_tready_q, s_tready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ENTRY_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                    end_q, end_d;

    assign in_upd  = (state == OP_CODE_WIDTH'(1));
    assign trigger = in_upd && !state1_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstate_q          <= L_IDLE;
            state1_prev_q     <= 1'b0;
            remaining_q       <= '0;
            addr_q            <= '0;
            slot_q            <= '0;
            beat_cnt_q        <= '0;
            buf_q             <= '0;
            entries_written_q <= '0;
            overflow_q        <= 1'b0;
            s_tready_q        <= 1'b0;
            wr_en_q           <= 1'b0;
            wr_addr_q         <= '0;
            wr_data_q         <= '0;
            end_q             <= 1'b0;
        end else begin
            lstate_q          <= lstate_d;
            state1_prev_q     <= in_upd;
            remaining_q       <= remaining_d;
            addr_q            <= addr_d;
            slot_q            <= slot_d;
            beat_cnt_q        <= beat_cnt_d;
            buf_q             <= buf_d;
            entries_written_q <= entries_written_d;
            overflow_q        <= overflow_d;
            s_tready_q        <= s_tready_d;
            wr_en_q           <= wr_en_d;
            wr_addr_q         <= wr_addr_d;
            wr_data_q         <= wr_data_d;
            end_q             <= end_d;
        end
    end

    always_comb begin
        lstate_d          = lstate_q;
        remaining_d       = remaining_q;
        addr_d            = addr_q;
        slot_d            = slot_q;
        beat_cnt_d        = beat_cnt_q;
        buf_d             = buf_q;
        entries_written_d = entries_written_q;
        overflow_d        = overflow_q;
        unique case (lstate_q)
            L_IDLE: begin
                if (trigger) begin
                    // Clamp keeps the write address inside the array, so it never wraps.
                    remaining_d       = (update_num > 32'(CAM_DEPTH)) ? 32'(CAM_DEPTH) : update_num;
                    overflow_d        = (update_num > 32'(CAM_DEPTH));
                    entries_written_d = '0;
                    addr_d            = '0;
                    lstate_d          = (update_num == 32'd0) ? L_DONE : L_LOAD;
                end
            end
            L_LOAD: begin
                if (!in_upd) begin
                    lstate_d = L_IDLE;
                end else if (s_tvalid && s_tready_q) begin
                    buf_d      = s_tdata;
                    beat_cnt_d = (remaining_q < 32'(EPB)) ? remaining_q[SLOT_W-1:0] : SLOT_W'(EPB);
                    slot_d     = '0;
                    lstate_d   = L_WRITE;
                end
            end
            L_WRITE: begin
                // The write presented this cycle completes even if an abort is seen.
                addr_d            = addr_q + ADDR_WIDTH'(1);
                slot_d            = slot_q + SLOT_W'(1);
                remaining_d       = remaining_q - 32'd1;
                entries_written_d = entries_written_q + 32'd1;
                if (!in_upd)
                    lstate_d = L_IDLE;
                else if (slot_d == beat_cnt_q)
                    lstate_d = (remaining_d == 32'd0) ? L_DONE : L_LOAD;
            end
            L_DONE:  lstate_d = L_IDLE;
            default: lstate_d = L_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        s_tready_d = (lstate_d == L_LOAD);
        wr_en_d    = (lstate_d == L_WRITE);
        end_d      = (lstate_d == L_DONE);
        wr_addr_d  = wr_en_d ? addr_d : '0;
        wr_data_d  = wr_en_d ? buf_d[slot_d*ENTRY_WIDTH +: ENTRY_WIDTH] : '0;
    end

    assign s_tready        = s_tready_q;
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign update_all_end  = end_q;
    assign overflow        = overflow_q;
    assign entries_written = entries_written_q;
endmodule

// File: tb/tb_cam_update_all_loader.sv
// Bench for cam_update_all_loader: table of UPDATE_ALL runs scored against a write queue,
// plus hand sequences for exact timing, stall/abort and asynchronous reset.
module tb_cam_update_all_loader;
    localparam int DW = 512, EW = 64, EPB = 8, DEPTH = 1024, AW = 10;

    logic           clk = 1'b0, rst_n = 1'b1;
    logic [2:0]     state = '0;
    logic [31:0]    update_num = '0;
    logic [DW-1:0]  s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready, wr_en, update_all_end, overflow;
    logic [AW-1:0]  wr_addr;
    logic [EW-1:0]  wr_data;
    logic [31:0]    entries_written;

    cam_update_all_loader dut (
        .clk(clk), .rst_n(rst_n), .state(state), .update_num(update_num),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .update_all_end(update_all_end), .overflow(overflow),
        .entries_written(entries_written)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [EW-1:0] d; } wr_t;
    typedef struct { logic [31:0] num; int exp_wr; int exp_beats; logic exp_ovf; } vec_t;

    wr_t           q[$];
    wr_t           acc_e, exp_e;
    int            checks = 0, failures = 0;
    int            model_rem = 0, n_acc = 0, n_wr = 0, n_end = 0;
    logic [AW-1:0] model_addr = '0;
    bit            use_fixed = 0;
    logic [DW-1:0] fixed_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Fresh beat data every cycle; stable across the sampling negedge.
    always @(posedge clk) begin
        #1;
        if (use_fixed) s_tdata = fixed_data;
        else for (int i = 0; i < DW/32; i++) s_tdata[i*32 +: 32] = $urandom;
    end

    // Scoreboard: accepted beats push expected writes, observed writes pop and compare.
    always @(negedge clk) begin
        if (s_tvalid && s_tready) begin
            n_acc++;
            for (int i = 0; i < EPB; i++) begin
                if (model_rem > 0) begin
                    acc_e.a = model_addr;
                    acc_e.d = s_tdata[i*EW +: EW];
                    q.push_back(acc_e);
                    model_addr++;
                    model_rem--;
                end
            end
        end
        if (wr_en) begin
            n_wr++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%0h required=none", wr_addr);
            end else begin
                exp_e = q.pop_front();
                chk("wr_addr", wr_addr, exp_e.a);
                chk("wr_data", wr_data, exp_e.d);
            end
        end
        if (update_all_end) n_end++;
    end

    task automatic start_op(input logic [31:0] num);
        update_num = num;
        model_rem  = (num > DEPTH) ? DEPTH : int'(num);
        model_addr = '0;
        n_acc = 0; n_wr = 0; n_end = 0;
        q.delete();
        @(posedge clk); #1 state = 3'd1;
    endtask

    task automatic run_op(input logic [31:0] num, output bit ended);
        start_op(num);
        ended = 0;
        for (int c = 0; c < 1500 && !ended; c++) begin
            @(negedge clk);
            if (update_all_end) ended = 1;
        end
        // state held at 1 and data still offered: no extra beat, no restart
        repeat (6) @(negedge clk);
        @(posedge clk); #1 state = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic trace_op(input logic [31:0] num, input int n, input logic [15:0] e_tr,
                            input logic [15:0] e_we, input logic [15:0] e_end, input string tag);
        start_op(num);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, "_tready"}, s_tready, e_tr[k]);
            chk({tag, "_wr_en"}, wr_en, e_we[k]);
            chk({tag, "_end"}, update_all_end, e_end[k]);
        end
        @(posedge clk); #1 state = 3'd0;
        repeat (3) @(posedge clk); #1;
        chk({tag, "_end_count"}, n_end, 1);
        chk({tag, "_entries"}, entries_written, num);
    endtask

    vec_t tbl[8];
    bit   ended;

    initial begin
        tbl[0] = '{32'd3,    3,    1,   1'b0};
        tbl[1] = '{32'd0,    0,    0,   1'b0};
        tbl[2] = '{32'd10,   10,   2,   1'b0};
        tbl[3] = '{32'd8,    8,    1,   1'b0};
        tbl[4] = '{32'd9,    9,    2,   1'b0};
        tbl[5] = '{32'd1024, 1024, 128, 1'b0};
        tbl[6] = '{32'd1025, 1024, 128, 1'b1};
        tbl[7] = '{32'd2000, 1024, 128, 1'b1};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tready", s_tready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_end", update_all_end, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_entries", entries_written, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Exact cycle timing: 3 entries {C,B,A} in one beat, then 0 entries.
        use_fixed = 1;
        fixed_data = '0;
        fixed_data[191:0] = {64'hCCCC_0003_3333_C0C0, 64'hBBBB_0002_2222_B0B0, 64'hAAAA_0001_1111_A0A0};
        s_tvalid = 1'b1;
        trace_op(32'd3, 9, 16'b0_0000_0010, 16'b0_0001_1100, 16'b0_0010_0000, "t1");
        trace_op(32'd0, 4, 16'b0000, 16'b0000, 16'b0010, "t2");
        use_fixed = 0;

        foreach (tbl[i]) begin
            s_tvalid = 1'b1;
            run_op(tbl[i].num, ended);
            chk($sformatf("v%0d_end_seen", i), ended, 1);
            chk($sformatf("v%0d_end_count", i), n_end, 1);
            chk($sformatf("v%0d_writes", i), n_wr, tbl[i].exp_wr);
            chk($sformatf("v%0d_beats", i), n_acc, tbl[i].exp_beats);
            chk($sformatf("v%0d_overflow", i), overflow, tbl[i].exp_ovf);
            chk($sformatf("v%0d_entries", i), entries_written, tbl[i].exp_wr);
            chk($sformatf("v%0d_pending", i), q.size(), 0);
        end

        // Stall in L_LOAD, then abort during L_WRITE.
        s_tvalid = 1'b0;
        start_op(32'd20);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_tready", s_tready, 1);
            chk("stall_wr_en", wr_en, 0);
        end
        @(posedge clk); #1 s_tvalid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_pre_wr_en", wr_en, 1);
        end
        @(posedge clk); #1 state = 3'd0;
        @(negedge clk);
        chk("abort_last_wr_en", wr_en, 1);
        @(negedge clk);
        chk("abort_wr_en_drop", wr_en, 0);
        chk("abort_tready_drop", s_tready, 0);
        repeat (10) @(negedge clk);
        chk("abort_end_count", n_end, 0);
        chk("abort_entries", entries_written, 4);
        chk("abort_writes", n_wr, 4);
        chk("abort_beats", n_acc, 1);
        q.delete();

        // Asynchronous reset in the middle of L_WRITE, then a clean restart.
        start_op(32'd2000);
        ended = 0;
        for (int c = 0; c < 50 && !ended; c++) begin
            @(negedge clk);
            if (wr_en) ended = 1;
        end
        repeat (2) @(negedge clk);
        chk("areset_write_seen", ended, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_tready", s_tready, 0);
        chk("areset_wr_en", wr_en, 0);
        chk("areset_wr_addr", wr_addr, 0);
        chk("areset_wr_data", wr_data, 0);
        chk("areset_end", update_all_end, 0);
        chk("areset_overflow", overflow, 0);
        chk("areset_entries", entries_written, 0);
        state = 3'd0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        run_op(32'd3, ended);
        chk("restart_end_seen", ended, 1);
        chk("restart_writes", n_wr, 3);
        chk("restart_entries", entries_written, 3);
        chk("restart_overflow", overflow, 0);
        s_tvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
